friscv_rd_writeback: RTL and testbench



---
 rtl/friscv_wb_pkg.sv | 30 +++
 rtl/friscv_wb_fifo.sv | 74 +++++++
 rtl/friscv_rd_writeback.sv | 177 +++++++++++++++++
 tb/tb_friscv_rd_writeback.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/friscv_wb_pkg.sv
// Shared types and constants for the register-file write-back collector.
package friscv_wb_pkg;

    localparam int unsigned REG_NB  = 32;
    localparam int unsigned REG_AW  = 5;
    // Register width carried by wb_req_t; the top-level XLEN must match it.
    localparam int unsigned WB_XLEN = 32;
    localparam int unsigned WB_STRB = WB_XLEN / 8;

    typedef struct packed {
        logic [REG_AW-1:0]  addr;
        logic [WB_XLEN-1:0] val;
        logic [WB_STRB-1:0] strb;
    } wb_req_t;

    typedef enum logic {
        SrcAlu   = 1'b0,
        SrcMemfy = 1'b1
    } wb_src_e;

    // One-hot of a register index; x0 never reports a pending write.
    function automatic logic [REG_NB-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
        logic [REG_NB-1:0] oh;
        oh       = '0;
        oh[addr] = 1'b1;
        oh[0]    = 1'b0;
        return oh;
    endfunction

endpackage

// File: rtl/friscv_wb_fifo.sv
// Per-source write-request FIFO; exposes its storage and occupancy mask so the
// top level can build the pending-write bitmap.
module friscv_wb_fifo
    import friscv_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  push_i,
    input  wb_req_t               data_i,
    input  logic                  pop_i,
    output wb_req_t               data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output wb_req_t [DEPTH-1:0]   entries_o,
    output logic [DEPTH-1:0]      valid_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PtrW-1:0]      wptr_q, wptr_d;
    logic [PtrW-1:0]      rptr_q, rptr_d;
    logic [DEPTH-1:0]     valid_q, valid_d;
    wb_req_t [DEPTH-1:0]  mem_q, mem_d;

    // Occupancy is tracked per slot rather than with a counter, which gives
    // full/empty and the pending mask directly.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        valid_d = valid_q;
        mem_d   = mem_q;
        if (srst) begin
            wptr_d  = '0;
            rptr_d  = '0;
            valid_d = '0;
        end else begin
            if (pop_i && valid_q[rptr_q]) begin
                valid_d[rptr_q] = 1'b0;
                rptr_d          = rptr_q + 1'b1;
            end
            if (push_i && !valid_q[wptr_q]) begin
                valid_d[wptr_q] = 1'b1;
                mem_d[wptr_q]   = data_i;
                wptr_d          = wptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge aclk) begin
        mem_q <= mem_d;
    end

    assign data_o    = mem_q[rptr_q];
    assign full_o    = &valid_q;
    assign empty_o   = ~|valid_q;
    assign entries_o = mem_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/friscv_rd_writeback.sv
// Write-back collector: queues ALU and memfy register writes, arbitrates them
// round-robin onto the register file's single write port.
// Optional: FRISCV_WB_PENDING_EN enables the pending-write bitmap.
module friscv_rd_writeback
    import friscv_wb_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic              alu_wb_valid,
    output logic              alu_wb_ready,
    input  logic [4:0]        alu_wb_addr,
    input  logic [XLEN-1:0]   alu_wb_val,
    input  logic [XLEN/8-1:0] alu_wb_strb,
    input  logic              memfy_wb_valid,
    output logic              memfy_wb_ready,
    input  logic [4:0]        memfy_wb_addr,
    input  logic [XLEN-1:0]   memfy_wb_val,
    input  logic [XLEN/8-1:0] memfy_wb_strb,
    output logic              rd_wr,
    output logic [4:0]        rd_addr,
    output logic [XLEN-1:0]   rd_val,
    output logic [XLEN/8-1:0] rd_strb,
    output logic [31:0]       pending,
    output logic              busy
);

    wb_req_t             alu_req, memfy_req;
    wb_req_t             alu_head, memfy_head;
    wb_req_t [DEPTH-1:0] alu_entries, memfy_entries;
    logic [DEPTH-1:0]    alu_valid, memfy_valid;
    logic                alu_full, alu_empty, memfy_full, memfy_empty;
    logic                alu_push, memfy_push;
    logic                grant_alu, grant_memfy;

    wb_src_e             last_q, last_d;
    logic                rd_wr_q, rd_wr_d;
    wb_req_t             rd_req_q, rd_req_d;

    assign alu_req.addr   = alu_wb_addr;
    assign alu_req.val    = alu_wb_val;
    assign alu_req.strb   = alu_wb_strb;
    assign memfy_req.addr = memfy_wb_addr;
    assign memfy_req.val  = memfy_wb_val;
    assign memfy_req.strb = memfy_wb_strb;

    // Ready depends only on registered occupancy, never on valid.
    assign alu_wb_ready   = aresetn & ~alu_full;
    assign memfy_wb_ready = aresetn & ~memfy_full;

    // Writes to x0 or with no byte enabled complete the handshake but are dropped.
    assign alu_push   = alu_wb_valid & ~alu_full & (alu_wb_addr != '0) & (|alu_wb_strb);
    assign memfy_push = memfy_wb_valid & ~memfy_full & (memfy_wb_addr != '0)
                        & (|memfy_wb_strb);

    friscv_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_alu_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .srst      (srst),
        .push_i    (alu_push),
        .data_i    (alu_req),
        .pop_i     (grant_alu),
        .data_o    (alu_head),
        .full_o    (alu_full),
        .empty_o   (alu_empty),
        .entries_o (alu_entries),
        .valid_o   (alu_valid)
    );

    friscv_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_memfy_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .srst      (srst),
        .push_i    (memfy_push),
        .data_i    (memfy_req),
        .pop_i     (grant_memfy),
        .data_o    (memfy_head),
        .full_o    (memfy_full),
        .empty_o   (memfy_empty),
        .entries_o (memfy_entries),
        .valid_o   (memfy_valid)
    );

    // last_q records the most recently granted source; a tie goes to the other.
    always_comb begin
        grant_alu   = 1'b0;
        grant_memfy = 1'b0;
        last_d      = last_q;
        if (!alu_empty && !memfy_empty) begin
            if (last_q == SrcMemfy) begin
                grant_alu = 1'b1;
            end else begin
                grant_memfy = 1'b1;
            end
        end else if (!alu_empty) begin
            grant_alu = 1'b1;
        end else if (!memfy_empty) begin
            grant_memfy = 1'b1;
        end
        if (grant_alu) begin
            last_d = SrcAlu;
        end
        if (grant_memfy) begin
            last_d = SrcMemfy;
        end
        if (srst) begin
            grant_alu   = 1'b0;
            grant_memfy = 1'b0;
            last_d      = SrcAlu;
        end
    end

    always_comb begin
        rd_wr_d  = grant_alu | grant_memfy;
        rd_req_d = rd_req_q;
        if (grant_alu) begin
            rd_req_d = alu_head;
        end else if (grant_memfy) begin
            rd_req_d = memfy_head;
        end
        if (srst) begin
            rd_wr_d  = 1'b0;
            rd_req_d = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_q   <= SrcAlu;
            rd_wr_q  <= 1'b0;
            rd_req_q <= '0;
        end else begin
            last_q   <= last_d;
            rd_wr_q  <= rd_wr_d;
            rd_req_q <= rd_req_d;
        end
    end

    assign rd_wr   = rd_wr_q;
    assign rd_addr = rd_req_q.addr;
    assign rd_val  = rd_req_q.val;
    assign rd_strb = rd_req_q.strb;
    assign busy    = ~alu_empty | ~memfy_empty | rd_wr_q;

`ifdef FRISCV_WB_PENDING_EN
    logic [REG_NB-1:0] pending_map;

    always_comb begin
        pending_map = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (alu_valid[i]) begin
                pending_map = pending_map | reg_onehot(alu_entries[i].addr);
            end
            if (memfy_valid[i]) begin
                pending_map = pending_map | reg_onehot(memfy_entries[i].addr);
            end
        end
        if (rd_wr_q) begin
            pending_map = pending_map | reg_onehot(rd_req_q.addr);
        end
    end

    assign pending = pending_map;
`else
    logic unused_pending_src;
    assign unused_pending_src = ^{alu_entries, alu_valid, memfy_entries, memfy_valid};
    assign pending            = '0;
`endif

endmodule

// File: tb/tb_friscv_rd_writeback.sv
// Scoreboard bench for friscv_rd_writeback against a queue-based reference model.
module tb_friscv_rd_writeback;

    localparam int DEPTH = 2;
`ifdef FRISCV_WB_PENDING_EN
    localparam logic PEN = 1'b1;
`else
    localparam logic PEN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        srst = 1'b0;
    logic        alu_wb_valid = 1'b0, memfy_wb_valid = 1'b0;
    logic        alu_wb_ready, memfy_wb_ready;
    logic [4:0]  alu_wb_addr = '0, memfy_wb_addr = '0;
    logic [31:0] alu_wb_val = '0, memfy_wb_val = '0;
    logic [3:0]  alu_wb_strb = '0, memfy_wb_strb = '0;
    logic        rd_wr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_val;
    logic [3:0]  rd_strb;
    logic [31:0] pending;
    logic        busy;

    always #5 aclk = ~aclk;

    friscv_rd_writeback #(
        .XLEN  (32),
        .DEPTH (DEPTH)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .srst           (srst),
        .alu_wb_valid   (alu_wb_valid),
        .alu_wb_ready   (alu_wb_ready),
        .alu_wb_addr    (alu_wb_addr),
        .alu_wb_val     (alu_wb_val),
        .alu_wb_strb    (alu_wb_strb),
        .memfy_wb_valid (memfy_wb_valid),
        .memfy_wb_ready (memfy_wb_ready),
        .memfy_wb_addr  (memfy_wb_addr),
        .memfy_wb_val   (memfy_wb_val),
        .memfy_wb_strb  (memfy_wb_strb),
        .rd_wr          (rd_wr),
        .rd_addr        (rd_addr),
        .rd_val         (rd_val),
        .rd_strb        (rd_strb),
        .pending        (pending),
        .busy           (busy)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] val;
        logic [3:0]  strb;
    } req_t;

    req_t q_alu[$];
    req_t q_mem[$];
    req_t exp_q[$];
    req_t out_req = '{addr: '0, val: '0, strb: '0};
    bit   out_valid = 1'b0;
    bit   last_alu = 1'b1;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_pending();
        logic [31:0] p;
        p = '0;
        foreach (q_alu[i]) p[q_alu[i].addr] = 1'b1;
        foreach (q_mem[i]) p[q_mem[i].addr] = 1'b1;
        if (out_valid) p[out_req.addr] = 1'b1;
        p[0] = 1'b0;
        return PEN ? p : 32'h0;
    endfunction

    // Reference model: state after each rising edge, built from the arbitration rules.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn || srst) begin
            q_alu.delete();
            q_mem.delete();
            out_valid = 1'b0;
            out_req   = '{addr: '0, val: '0, strb: '0};
            last_alu  = 1'b1;
        end else begin
            bit   ra, rm, any;
            req_t g, r;
            ra  = q_alu.size() < DEPTH;
            rm  = q_mem.size() < DEPTH;
            any = 1'b0;
            if (q_alu.size() > 0 && (q_mem.size() == 0 || !last_alu)) begin
                g = q_alu.pop_front(); last_alu = 1'b1; any = 1'b1;
            end else if (q_mem.size() > 0) begin
                g = q_mem.pop_front(); last_alu = 1'b0; any = 1'b1;
            end
            out_valid = any;
            if (any) begin
                out_req = g;
                exp_q.push_back(g);
            end
            if (alu_wb_valid && ra) begin
                r = '{addr: alu_wb_addr, val: alu_wb_val, strb: alu_wb_strb};
                if (r.addr != 0 && r.strb != 0) q_alu.push_back(r);
            end
            if (memfy_wb_valid && rm) begin
                r = '{addr: memfy_wb_addr, val: memfy_wb_val, strb: memfy_wb_strb};
                if (r.addr != 0 && r.strb != 0) q_mem.push_back(r);
            end
        end
    end

    // Monitor: compares every cycle; write payloads come from the scoreboard queue.
    always @(negedge aclk) begin
        if (mon_en && aresetn) begin
            req_t e;
            check("alu_ready", 64'(alu_wb_ready), 64'(q_alu.size() < DEPTH));
            check("memfy_ready", 64'(memfy_wb_ready), 64'(q_mem.size() < DEPTH));
            check("busy", 64'(busy), 64'(q_alu.size() != 0 || q_mem.size() != 0 || out_valid));
            check("pending", 64'(pending), 64'(exp_pending()));
            check("rd_wr", 64'(rd_wr), 64'(out_valid));
            if (rd_wr) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 64'(rd_addr), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_addr", 64'(rd_addr), 64'(e.addr));
                    check("rd_val", 64'(rd_val), 64'(e.val));
                    check("rd_strb", 64'(rd_strb), 64'(e.strb));
                end
            end else begin
                check("rd_addr_hold", 64'(rd_addr), 64'(out_req.addr));
                check("rd_val_hold", 64'(rd_val), 64'(out_req.val));
            end
        end
    end

    // Hold valid and payload until a cycle with ready high has passed its edge.
    task automatic send(input int src, input logic [4:0] a, input logic [31:0] v,
                        input logic [3:0] s);
        int   t;
        logic r;
        t = 0;
        if (src == 0) begin
            alu_wb_valid = 1'b1; alu_wb_addr = a; alu_wb_val = v; alu_wb_strb = s;
        end else begin
            memfy_wb_valid = 1'b1; memfy_wb_addr = a; memfy_wb_val = v; memfy_wb_strb = s;
        end
        forever begin
            @(negedge aclk);
            r = (src == 0) ? alu_wb_ready : memfy_wb_ready;
            @(posedge aclk);
            #1;
            if (r) break;
            t++;
            if (t > 100) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: src %0d ready stuck low, required high", src);
                break;
            end
        end
        if (src == 0) alu_wb_valid = 1'b0;
        else memfy_wb_valid = 1'b0;
    endtask

    task automatic stream(input int src, input int n, input bit rnd);
        logic [4:0]  a;
        logic [3:0]  s;
        for (int i = 0; i < n; i++) begin
            a = rnd ? 5'($urandom_range(0, 31)) : 5'((src == 0) ? 1 + (i % 15) : 16 + (i % 16));
            s = rnd ? 4'($urandom_range(0, 15)) : 4'hF;
            send(src, a, $urandom, s);
            if (rnd) begin
                repeat ($urandom_range(0, 2)) @(posedge aclk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic pulse_srst();
        srst = 1'b1;
        @(posedge aclk);
        #1;
        srst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_alu_ready", 64'(alu_wb_ready), 64'h0);
        check("rst_memfy_ready", 64'(memfy_wb_ready), 64'h0);
        check("rst_rd_wr", 64'(rd_wr), 64'h0);
        check("rst_rd_addr", 64'(rd_addr), 64'h0);
        check("rst_rd_val", 64'(rd_val), 64'h0);
        check("rst_rd_strb", 64'(rd_strb), 64'h0);
        check("rst_pending", 64'(pending), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        mon_en  = 1'b1;
        idle(3);

        // Single ALU write: two-cycle latency, pending over the queued and output cycles.
        send(0, 5'd5, 32'hDEADBEEF, 4'hF);
        @(negedge aclk);
        check("t1_rd_wr_c1", 64'(rd_wr), 64'h0);
        check("t1_pending_c1", 64'(pending[5]), 64'(PEN));
        @(negedge aclk);
        check("t1_rd_wr_c2", 64'(rd_wr), 64'h1);
        check("t1_rd_addr", 64'(rd_addr), 64'h5);
        check("t1_rd_val", 64'(rd_val), 64'hDEADBEEF);
        check("t1_pending_c2", 64'(pending[5]), 64'(PEN));
        @(negedge aclk);
        check("t1_rd_wr_c3", 64'(rd_wr), 64'h0);
        check("t1_pending_c3", 64'(pending), 64'h0);
        idle(2);

        // memfy granted last, then srst must return the tie-break to memfy-first.
        send(1, 5'd9, 32'h1234, 4'h3);
        idle(4);
        pulse_srst();
        idle(1);
        fork
            send(0, 5'd3, 32'h33333333, 4'hF);
            send(1, 5'd4, 32'h44444444, 4'hF);
        join
        @(negedge aclk);
        check("t2_rd_wr_c1", 64'(rd_wr), 64'h0);
        @(negedge aclk);
        check("t2_first_addr", 64'(rd_addr), 64'h4);
        @(negedge aclk);
        check("t2_second_addr", 64'(rd_addr), 64'h3);
        idle(3);

        // Filtered requests: handshake completes, nothing reaches the port.
        fork
            send(0, 5'd0, 32'hAAAA5555, 4'hF);
            send(1, 5'd7, 32'h5555AAAA, 4'h0);
        join
        repeat (3) begin
            @(negedge aclk);
            check("t3_rd_wr", 64'(rd_wr), 64'h0);
            check("t3_busy", 64'(busy), 64'h0);
            check("t3_pending", 64'(pending), 64'h0);
        end
        idle(1);

        // ALU burst at full rate.
        for (int i = 0; i < 6; i++) send(0, 5'(i + 10), $urandom, 4'hF);
        idle(4);

        // Continuous contention: alternation, both queues fill.
        fork
            stream(0, 8, 1'b0);
            stream(1, 8, 1'b0);
        join
        idle(6);

        // srst with both queues full mid-stream.
        fork
            stream(0, 8, 1'b0);
            stream(1, 8, 1'b0);
            begin
                idle(6);
                pulse_srst();
                @(negedge aclk);
                check("srst_alu_ready", 64'(alu_wb_ready), 64'h1);
                check("srst_memfy_ready", 64'(memfy_wb_ready), 64'h1);
                check("srst_busy", 64'(busy), 64'h0);
                check("srst_pending", 64'(pending), 64'h0);
                check("srst_rd_wr", 64'(rd_wr), 64'h0);
            end
        join
        idle(6);

        // Randomised traffic with gaps, filtered entries and address reuse.
        fork
            stream(0, 80, 1'b1);
            stream(1, 80, 1'b1);
        join
        idle(10);
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
